// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle RV64 control FSM with retired-instruction counter; `MULTICYCLE_CTRL_MEM_WAIT_EN adds mem_ready stalls
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             zero,
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  input  logic             mem_ready,
`endif
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src,
  output logic [3:0]       alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd5} state_t;
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SUB = 4'b0110;
  state_t     st;
  logic       ready, run, r_t, i_t, ld_t, sd_t, br_t, legal, dec_src, active;
  logic [3:0] dec_op;
  logic       ld_q, sd_q, br_q, bne_q, src_q;
  logic [3:0] op_q;
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif
  assign r_t   = opcode == 7'b0110011;
  assign i_t   = opcode == 7'b0010011;
  assign ld_t  = opcode == 7'b0000011;
  assign sd_t  = opcode == 7'b0100011;
  assign br_t  = opcode == 7'b1100011;
  assign legal = ((r_t | i_t) & (funct3 inside {3'b000, 3'b110, 3'b111}))
               | ((ld_t | sd_t) & (funct3 == 3'b011))
               | (br_t & (funct3[2:1] == 2'b00));
  assign dec_op = (ld_t | sd_t)          ? OP_ADD :
                  br_t                   ? OP_SUB :
                  (funct3 == 3'b110)     ? OP_OR  :
                  (funct3 == 3'b111)     ? OP_AND :
                  (r_t & funct7b5)       ? OP_SUB : OP_ADD;
  assign dec_src = i_t | ld_t | sd_t;
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= FETCH;
      instret <= '0;
      {ld_q, sd_q, br_q, bne_q, src_q} <= '0;
      op_q    <= '0;
    end else begin
      // a held memory cycle keeps pc_write up but retires only once ready
      if (pc_write && (st != MEM || ready)) instret <= instret + CNT_W'(1);
      case (st)
        FETCH:  st <= ready ? DECODE : FETCH;
        DECODE: begin
          {ld_q, sd_q, br_q, bne_q} <= {ld_t, sd_t, br_t, br_t & funct3[0]};
          {op_q, src_q} <= {dec_op, dec_src};
          st <= legal ? EXEC : TRAP;
        end
        EXEC:   st <= br_q ? FETCH : (ld_q | sd_q) ? MEM : WB;
        MEM:    st <= !ready ? MEM : sd_q ? FETCH : WB;
        WB:     st <= FETCH;
        default: st <= TRAP;
      endcase
    end
  end
  assign run        = !rst;
  assign active     = run & (st == EXEC || st == MEM || st == WB);
  assign state      = st;
  assign ir_write   = run & (st == FETCH);
  assign pc_write   = run & ((st == EXEC & br_q) | (st == MEM & sd_q) | (st == WB));
  assign pc_src     = run & (st == EXEC) & br_q & (zero ^ bne_q);
  assign alu_src    = active & src_q;
  assign alu_op     = active ? op_q : 4'b0000;
  assign mem_read   = run & (st == MEM) & ld_q;
  assign mem_write  = run & (st == MEM) & sd_q;
  assign mem_to_reg = run & (st == WB) & ld_q;
  assign reg_write  = run & (st == WB);
  assign illegal    = run & (st == TRAP);
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench; per-cycle expectations built from instruction-class phase lists
module tb_multicycle_ctrl;
  localparam int CW = 4;
  localparam logic [7:0] IR = 8'h80, PCW = 8'h40, PCS = 8'h20, MR = 8'h10, MW = 8'h08, M2R = 8'h04, RW = 8'h02, ILL = 8'h01;
  typedef struct {
    logic [2:0] st;
    bit         cs;
    logic [7:0] ctl;
    bit         ca;
    logic [4:0] alu;
    logic [CW-1:0] cnt;
  } rec_t;
  logic clk = 0, rst = 1, funct7b5 = 0, zero = 0, mem_ready = 1;
  logic [6:0] opcode = 0;
  logic [2:0] funct3 = 0;
  logic ir_write, pc_write, pc_src, alu_src, mem_read, mem_write, mem_to_reg, reg_write, illegal;
  logic [3:0] alu_op;
  logic [2:0] state;
  logic [CW-1:0] instret;
  logic [CW-1:0] cnt_m = 0;
  rec_t exp_q[$];
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .state(state), .instret(instret));
  function automatic rec_t mk(logic [2:0] s, logic [7:0] c, bit a, logic [4:0] al);
    rec_t r;
    r.st = s; r.cs = 1; r.ctl = c; r.ca = a; r.alu = al; r.cnt = '0;
    return r;
  endfunction
  always @(negedge clk) begin
    rec_t e;
    logic [7:0] act;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      act = {ir_write, pc_write, pc_src, mem_read, mem_write, mem_to_reg, reg_write, illegal};
      checks++;
      if (act !== e.ctl) begin errors++; $display("FAIL ctrl t=%0t: got %b want %b", $time, act, e.ctl); end
      checks++;
      if (instret !== e.cnt) begin errors++; $display("FAIL instret t=%0t: got %0d want %0d", $time, instret, e.cnt); end
      if (e.cs) begin
        checks++;
        if (state !== e.st) begin errors++; $display("FAIL state t=%0t: got %0d want %0d", $time, state, e.st); end
      end
      if (e.ca) begin
        checks++;
        if ({alu_op, alu_src} !== e.alu) begin
          errors++; $display("FAIL alu t=%0t: got op=%b src=%b want op=%b src=%b", $time, alu_op, alu_src, e.alu[4:1], e.alu[0]);
        end
      end
    end
  end
  task automatic step(input rec_t r);
    r.cnt = cnt_m;
    exp_q.push_back(r);
    @(posedge clk); #1;
  endtask
  task automatic cyc(input rec_t r);
`ifdef MULTICYCLE_CTRL_MEM_WAIT_EN
    if (r.st == 3'd0 || r.st == 3'd3) begin
      repeat (($urandom % 3 == 0) ? $urandom_range(1, 4) : 0) begin
        mem_ready = 0;
        step(r);
      end
    end
    mem_ready = 1;
`endif
    step(r);
    if ((r.ctl & PCW) != 0) cnt_m = cnt_m + 1'b1;
  endtask
  task automatic reset_seq();
    rec_t r;
    rst = 1;
    r = mk(3'd0, 8'h00, 0, 5'd0);
    r.cs = 0;
    step(r);
    cnt_m = 0;
    step(mk(3'd0, 8'h00, 0, 5'd0));
    rst = 0;
  endtask
  task automatic run_instr(input logic [31:0] w, input bit z, input int abort);
    rec_t ph[$];
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] aop;
    bit arith, ld, sd, br, taken, cut;
    op = w[6:0]; f3 = w[14:12];
    opcode = op; funct3 = f3; funct7b5 = w[30]; zero = z;
    arith = (op == 7'h33 || op == 7'h13) && (f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd7);
    ld = op == 7'h03 && f3 == 3'd3;
    sd = op == 7'h23 && f3 == 3'd3;
    br = op == 7'h63 && f3 <= 3'd1;
    aop = (f3 == 3'd6) ? 4'b0001 : (f3 == 3'd7) ? 4'b0000 : (op == 7'h33 && w[30]) ? 4'b0110 : 4'b0010;
    taken = (f3 == 3'd0) ? z : !z;
    ph.push_back(mk(3'd0, IR, 0, 5'd0));
    ph.push_back(mk(3'd1, 8'h00, 0, 5'd0));
    if (arith) begin
      ph.push_back(mk(3'd2, 8'h00, 1, {aop, op == 7'h13}));
      ph.push_back(mk(3'd4, PCW | RW, 1, {aop, op == 7'h13}));
    end else if (ld) begin
      ph.push_back(mk(3'd2, 8'h00, 1, {4'b0010, 1'b1}));
      ph.push_back(mk(3'd3, MR, 0, 5'd0));
      ph.push_back(mk(3'd4, PCW | M2R | RW, 0, 5'd0));
    end else if (sd) begin
      ph.push_back(mk(3'd2, 8'h00, 1, {4'b0010, 1'b1}));
      ph.push_back(mk(3'd3, MW | PCW, 0, 5'd0));
    end else if (br) begin
      ph.push_back(mk(3'd2, PCW | (taken ? PCS : 8'h00), 1, {4'b0110, 1'b0}));
    end else begin
      repeat ($urandom_range(2, 4)) ph.push_back(mk(3'd5, ILL, 0, 5'd0));
    end
    cut = abort > 0 && abort < ph.size();
    foreach (ph[i]) begin
      if (cut && i == abort) break;
      cyc(ph[i]);
    end
    if (cut || !(arith || ld || sd || br)) reset_seq();
  endtask
  logic [6:0] ops[6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h7F};
  logic [2:0] good3[3] = '{3'd0, 3'd6, 3'd7};
  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    @(posedge clk); #1;
    repeat (2) step(mk(3'd0, 8'h00, 0, 5'd0));
    rst = 0;
    run_instr(32'h00B50533, 0, 0);
    run_instr(32'h40B50533, 0, 0);
    run_instr(32'h00053283, 0, 0);
    run_instr(32'h00553023, 0, 0);
    run_instr(32'h00000063, 1, 0);
    run_instr(32'h00001063, 1, 0);
    run_instr(32'h0000007F, 0, 0);
    repeat (20) run_instr(32'h00B50533, $urandom % 2, 0);
    repeat (300) begin
      op = ops[($urandom % 16 == 0) ? 5 : $urandom % 5];
      f3 = (op == 7'h03 || op == 7'h23) ? 3'd3 : (op == 7'h63) ? 3'($urandom % 2) : good3[$urandom % 3];
      if ($urandom % 6 == 0) f3 = 3'($urandom % 8);
      run_instr(32'(op) | (32'(f3) << 12) | (32'($urandom % 2) << 30), $urandom % 2,
                ($urandom % 20 == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL drain: got %0d pending want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
